memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter READ_LATENCY, default 1: cycles from the memory issue edge to a valid dataOutput (legal range 1..4).
REQ-002 Parameter RR_ENABLE, default 1: 1 = round-robin arbitration, 0 = fixed priority with port A highest.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 a_req  input  1  port A (CPU load/store) request; held high until a_ack.
REQ-006 a_address  input  32  port A byte address.
REQ-007 a_data  input  32  port A store data.
REQ-008 a_writeMode, a_readMode  input  3 each  port A access mode (NONE/WORD/HALFWORD/BYTE/WORDLEFT/WORDRIGHT encoding).
REQ-009 a_unsignedLoad  input  1  port A zero-extend select.
REQ-010 a_ack  output  1  one-cycle completion pulse to port A.
REQ-011 a_rdata  output  32  port A load result; valid when a_ack is high, held until the next port A read completes.
REQ-012 b_req, b_address, b_data, b_writeMode, b_readMode, b_unsignedLoad, b_ack, b_rdata: port B (loader/debug), same directions, widths and meanings as port A.
REQ-013 address, data  output  32 each  to the memory data port.
REQ-014 writeMode, readMode  output  3 each  to the memory data port.
REQ-015 unsignedLoad  output  1  to the memory data port.
REQ-016 dataOutput  input  32  load data from the memory data port.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE transitions:
- IDLE -> ISSUE when any req is high.
- The winner's address, data, modes and unsignedLoad are latched into a request register on that edge.
- The winner's ID is latched into a grant register on that edge.
REQ-019 ISSUE lasts exactly one cycle and drives the latched request onto the memory outputs.
REQ-020 In every state other than ISSUE, writeMode and readMode are NONE, address and data are 0, and unsignedLoad is 0.
REQ-021 Write requests (writeMode != NONE):
- The read is suppressed: readMode is driven NONE.
- ISSUE -> RESP.
REQ-022 Read requests (writeMode == NONE, readMode != NONE):
- ISSUE -> WAIT.
- A latency counter loads READ_LATENCY-1 at ISSUE.
- WAIT -> RESP when the counter is 0; dataOutput is captured into the granted port's rdata on that edge.
REQ-023 A request with both modes NONE goes ISSUE -> RESP, with no memory access and rdata unchanged.
REQ-024 RESP lasts one cycle, pulses the granted port's ack, then returns to IDLE.
- Exactly one ack is high per RESP.
- Ack is never high outside RESP.
REQ-025 A req still high in the cycle after its ack is treated as a new request.
REQ-026 Round-robin (RR_ENABLE=1):
- When both reqs are high in IDLE, the port not granted last wins.
- When a single req is high, it wins regardless of history.
REQ-027 Fixed priority (RR_ENABLE=0): A wins whenever a_req is high in IDLE.
REQ-028 Requester inputs are ignored outside the IDLE arbitration edge; changes mid-transaction do not affect the access in flight.
REQ-029 Throughput and latency:
- Back-to-back write: 3 cycles from req to ack (IDLE, ISSUE, RESP).
- Read: 3+READ_LATENCY cycles from req to ack.

Reset
REQ-030 While rst is high at a clock edge:
- State becomes IDLE and the counter is cleared.
- a_ack and b_ack are 0; a_rdata and b_rdata are 0x0.
- The last-grant register is set to B, so A wins the first contention.
REQ-031 A reset asserted during ISSUE or WAIT aborts the transaction with no ack; memory outputs return to NONE on the next cycle.

Verification
REQ-032 A alone, WORD write 0x22345678 @65532: ISSUE drives writeMode=WORD, address=65532; a_ack pulses 3 cycles after req. Then A WORD read @65532: a_rdata=0x22345678 with a_ack at cycle 4 (READ_LATENCY=1).
REQ-033 Both reqs high in the same cycle after reset, RR_ENABLE=1: A served first, then B. Both held continuously: grants alternate A,B,A,B across 4 transactions.
REQ-034 RR_ENABLE=0, A and B held continuously for 4 transactions: A granted every time, b_ack never pulses.
REQ-035 B HALFWORD read of 0xFFFF @65528 with unsignedLoad=0: unsignedLoad=0 presented at ISSUE; b_rdata=0xFFFFFFFF, a_rdata unchanged.
REQ-036 rst pulsed during WAIT of an A read: no a_ack, a_rdata=0, memory modes NONE next cycle. A re-issued read completes normally.
REQ-037 A request with writeMode=BYTE and readMode=WORD: only the write is issued (readMode=NONE at ISSUE); ack arrives at 3 cycles and rdata is unchanged.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-port memory arbiter: round-robin or fixed-priority access
// to one memory data port with a configurable read latency.
module memory_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter bit RR_ENABLE    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [31:0] a_address,
  input  logic [31:0] a_data,
  input  logic [2:0]  a_writeMode,
  input  logic [2:0]  a_readMode,
  input  logic        a_unsignedLoad,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic [31:0] b_address,
  input  logic [31:0] b_data,
  input  logic [2:0]  b_writeMode,
  input  logic [2:0]  b_readMode,
  input  logic        b_unsignedLoad,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic [31:0] address,
  output logic [31:0] data,
  output logic [2:0]  writeMode,
  output logic [2:0]  readMode,
  output logic        unsignedLoad,
  input  logic [31:0] dataOutput
);
  localparam logic [2:0] MODE_NONE = 3'd0;
  localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [2:0]  wm_q, wm_d;
  logic [2:0]  rm_q, rm_d;
  logic        uns_q, uns_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic        pick_b;

  // gnt_q doubles as the last-grant history for round-robin
  always_comb begin
    if (RR_ENABLE) begin
      pick_b = b_req && (!a_req || gnt_q == GNT_A);
    end else begin
      pick_b = b_req && !a_req;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    wdat_d       = wdat_q;
    wm_d         = wm_q;
    rm_d         = rm_q;
    uns_d        = uns_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    address      = '0;
    data         = '0;
    writeMode    = MODE_NONE;
    readMode     = MODE_NONE;
    unsignedLoad = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          state_d = ISSUE;
          gnt_d   = pick_b;
          if (pick_b) begin
            addr_d = b_address;
            wdat_d = b_data;
            wm_d   = b_writeMode;
            rm_d   = b_readMode;
            uns_d  = b_unsignedLoad;
          end else begin
            addr_d = a_address;
            wdat_d = a_data;
            wm_d   = a_writeMode;
            rm_d   = a_readMode;
            uns_d  = a_unsignedLoad;
          end
        end
      end
      ISSUE: begin
        address      = addr_q;
        data         = wdat_q;
        writeMode    = wm_q;
        readMode     = (wm_q != MODE_NONE) ? MODE_NONE : rm_q;
        unsignedLoad = uns_q;
        cnt_d        = LAT_M1;
        if (wm_q == MODE_NONE && rm_q != MODE_NONE) begin
          state_d = WAIT;
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = RESP;
          if (gnt_q == GNT_B) begin
            b_rdata_d = dataOutput;
          end else begin
            a_rdata_d = dataOutput;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      gnt_q     <= GNT_B;
      addr_q    <= '0;
      wdat_q    <= '0;
      wm_q      <= MODE_NONE;
      rm_q      <= MODE_NONE;
      uns_q     <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      wm_q      <= wm_d;
      rm_q      <= rm_d;
      uns_q     <= uns_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_ack   = (state_q == RESP) && (gnt_q == GNT_A);
  assign b_ack   = (state_q == RESP) && (gnt_q == GNT_B);
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule
